// File: rtl/bcd_display_scanner.sv
// Scans a latched 3-digit BCD score onto a shared active-low 7-segment bus.
// New scores are committed only at frame boundaries so no frame mixes digits.
module bcd_display_scanner #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int SCAN_RATE  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    input  logic        blank_en,
    output logic        update_ack,
    output logic [6:0]  seg,
    output logic [2:0]  digit_en
);

    localparam int TICK_RAW = CLOCK_FREQ / SCAN_RATE;
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic [11:0]   display_reg;
    logic [11:0]   pending_reg;
    logic          pending_flag;
    logic          tick;
    logic          frame_end;
    logic [3:0]    nibble;
    logic          blank_digit;
    logic [6:0]    seg_next;
    logic [2:0]    en_next;

    assign tick      = (prescaler == TICK_LAST);
    assign frame_end = tick && (index == 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            index     <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            index     <= (index == 2'd2) ? 2'd0 : index + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // bcd_valid is a one-cycle strobe with no back-pressure: bcd_in is taken
    // in every cycle it is high, and the newest value always wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            display_reg  <= 12'h000;
            pending_reg  <= 12'h000;
            pending_flag <= 1'b0;
            update_ack   <= 1'b0;
        end else if (frame_end) begin
            if (bcd_valid) begin
                display_reg  <= bcd_in;
                pending_flag <= 1'b0;
                update_ack   <= 1'b1;
            end else if (pending_flag) begin
                display_reg  <= pending_reg;
                pending_flag <= 1'b0;
                update_ack   <= 1'b1;
            end else begin
                update_ack   <= 1'b0;
            end
        end else begin
            update_ack <= 1'b0;
            if (bcd_valid) begin
                pending_reg  <= bcd_in;
                pending_flag <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] decode_digit(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // A dash nibble is non-zero, so it stops leading-zero blanking naturally.
    always_comb begin
        nibble      = display_reg[3:0];
        en_next     = 3'b110;
        blank_digit = 1'b0;
        case (index)
            2'd1: begin
                nibble      = display_reg[7:4];
                en_next     = 3'b101;
                blank_digit = blank_en && (display_reg[11:8] == 4'd0)
                              && (display_reg[7:4] == 4'd0);
            end
            2'd2: begin
                nibble      = display_reg[11:8];
                en_next     = 3'b011;
                blank_digit = blank_en && (display_reg[11:8] == 4'd0);
            end
            default: ;
        endcase
        seg_next = blank_digit ? 7'h7F : decode_digit(nibble);
    end

    // seg and digit_en share one register stage so they always switch together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg      <= 7'h7F;
            digit_en <= 3'b111;
        end else begin
            seg      <= seg_next;
            digit_en <= en_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: cycle-count reference model checked every
// cycle, plus directed frames with hand-computed segment values.
module tb_bcd_display_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] bcd_in = 12'h000;
    logic        bcd_valid = 1'b0;
    logic        blank_en = 1'b0;
    logic        update_ack;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    int n_checks = 0;
    int n_fail = 0;

    bcd_display_scanner #(.CLOCK_FREQ(8), .SCAN_RATE(2)) dut (
        .clock(clock),
        .reset(reset),
        .bcd_in(bcd_in),
        .bcd_valid(bcd_valid),
        .blank_en(blank_en),
        .update_ack(update_ack),
        .seg(seg),
        .digit_en(digit_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset is counted in edges; with four
    // clocks per digit and three digits, a frame is 12 edges and the edge
    // numbered 11 mod 12 ends it.
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [2:0]  en_tab [3]   = '{3'b110, 3'b101, 3'b011};
    int          cyc = 0;
    logic [11:0] m_disp = 12'h000;
    logic [11:0] m_pend = 12'h000;
    bit          m_pend_v = 1'b0;
    logic [6:0]  exp_seg = 7'h7F;
    logic [2:0]  exp_en = 3'b111;
    logic        exp_ack = 1'b0;
    int          m_idx;
    bit          m_bnd;

    function automatic logic [6:0] model_seg(input logic [11:0] v, input int idx, input logic blank);
        int d[3];
        for (int k = 0; k < 3; k++) d[k] = (int'(v) >> (4 * k)) % 16;
        if (blank && idx == 2 && d[2] == 0) return 7'h7F;
        if (blank && idx == 1 && d[2] == 0 && d[1] == 0) return 7'h7F;
        if (d[idx] > 9) return 7'h3F;
        return seg_tab[d[idx]];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc      = 0;
            m_disp   = 12'h000;
            m_pend   = 12'h000;
            m_pend_v = 1'b0;
            exp_seg  = 7'h7F;
            exp_en   = 3'b111;
            exp_ack  = 1'b0;
        end else begin
            m_idx   = (cyc / 4) % 3;
            exp_seg = model_seg(m_disp, m_idx, blank_en);
            exp_en  = en_tab[m_idx];
            m_bnd   = (cyc % 12) == 11;
            exp_ack = m_bnd && (bcd_valid || m_pend_v);
            if (m_bnd) begin
                if (bcd_valid) begin
                    m_disp   = bcd_in;
                    m_pend_v = 1'b0;
                end else if (m_pend_v) begin
                    m_disp   = m_pend;
                    m_pend_v = 1'b0;
                end
            end else if (bcd_valid) begin
                m_pend   = bcd_in;
                m_pend_v = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clock) begin
        check("seg", 32'(seg), 32'(exp_seg));
        check("digit_en", 32'(digit_en), 32'(exp_en));
        check("update_ack", 32'(update_ack), 32'(exp_ack));
    end

    // Drive a one-cycle bcd_valid so the DUT samples it on the edge whose
    // model edge number is 'phase' mod 12.
    task automatic pulse_at(input int phase, input logic [11:0] v);
        int tries = 0;
        @(negedge clock);
        while ((cyc % 12) != phase && tries < 30) begin
            @(negedge clock);
            tries++;
        end
        check("phase_wait", 32'(tries < 30), 32'd1);
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clock);
        bcd_valid = 1'b0;
        bcd_in    = 12'($urandom_range(0, 4095));
    endtask

    task automatic wait_ack(input int max_cycles);
        int n = 0;
        while (!update_ack && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check("ack_seen", 32'(update_ack), 32'd1);
    endtask

    task automatic count_acks(input int n, input int expected);
        int c = 0;
        repeat (n) begin
            @(negedge clock);
            if (update_ack) c++;
        end
        check("ack_count", 32'(c), 32'(expected));
    endtask

    task automatic check_frame(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
        repeat (12) begin
            @(negedge clock);
            case (digit_en)
                3'b110:  check("frame_units", 32'(seg), 32'(u));
                3'b101:  check("frame_tens", 32'(seg), 32'(t));
                3'b011:  check("frame_hundreds", 32'(seg), 32'(h));
                default: check("frame_digit_en", 32'(digit_en), 32'h6);
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] hh, tt, uu;
        repeat (3) @(negedge clock);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_digit_en", 32'(digit_en), 32'h7);
        check("reset_ack", 32'(update_ack), 32'd0);
        reset = 1'b0;

        @(negedge clock);
        check("release_seg", 32'(seg), 32'h40);
        check("release_digit_en", 32'(digit_en), 32'h6);
        repeat (4) @(negedge clock);
        check("scan_tens", 32'(digit_en), 32'h5);
        repeat (4) @(negedge clock);
        check("scan_hundreds", 32'(digit_en), 32'h3);
        repeat (4) @(negedge clock);
        check("scan_wrap", 32'(digit_en), 32'h6);

        pulse_at(1, 12'h125);
        wait_ack(20);
        check_frame(7'h12, 7'h24, 7'h79);

        blank_en = 1'b1;
        pulse_at(2, 12'h007);
        wait_ack(20);
        check_frame(7'h78, 7'h7F, 7'h7F);
        pulse_at(5, 12'h000);
        wait_ack(20);
        check_frame(7'h40, 7'h7F, 7'h7F);
        blank_en = 1'b0;
        pulse_at(0, 12'h007);
        wait_ack(20);
        check_frame(7'h78, 7'h40, 7'h40);
        blank_en = 1'b1;
        pulse_at(9, 12'h0A3);
        wait_ack(20);
        check_frame(7'h30, 7'h3F, 7'h7F);

        blank_en = 1'b0;
        pulse_at(0, 12'h111);
        pulse_at(3, 12'h222);
        count_acks(13, 1);
        check_frame(7'h24, 7'h24, 7'h24);

        pulse_at(11, 12'h456);
        check("simul_ack", 32'(update_ack), 32'd1);
        count_acks(13, 0);
        check_frame(7'h02, 7'h12, 7'h19);

        pulse_at(1, 12'h999);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_digit_en", 32'(digit_en), 32'h7);
        check("async_reset_ack", 32'(update_ack), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        count_acks(30, 0);
        check_frame(7'h40, 7'h40, 7'h40);

        repeat (3000) begin
            @(negedge clock);
            bcd_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                hh = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
                tt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
                uu = 4'($urandom_range(0, 9));
                bcd_in = {hh, tt, uu};
            end else begin
                bcd_in = 12'($urandom_range(0, 4095));
            end
            if ($urandom_range(0, 63) == 0) blank_en = ~blank_en;
        end
        bcd_valid = 1'b0;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the 12-bit, 3-digit BCD word produced by the double-dabble shifter chain (units in [3:0], tens in [7:4], hundreds in [11:8]).
- Latches a new score on a valid strobe and holds it in a shadow register.
- Commits the value to the display only at a scan-frame boundary, so a frame never shows a mix of old and new digits.
- Time-multiplexes the three digits onto a shared active-low 7-segment bus, with optional leading-zero blanking and a dash for non-decimal nibbles.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- SCAN_RATE, 1000, digit-advance rate in Hz. TICK_DIV = CLOCK_FREQ/SCAN_RATE, integer division. If the result is 0, TICK_DIV is treated as 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bcd_in  input  12  BCD score from the double-dabble stage.
- bcd_valid  input  1  single-cycle strobe; captures bcd_in.
- blank_en  input  1  1 = suppress leading zeros.
- update_ack  output  1  one-cycle pulse when a pending value is committed to the display.
- seg  output  7  {g,f,e,d,c,b,a}, active-low (0 = segment lit).
- digit_en  output  3  active-low digit select; bit0 = units, bit1 = tens, bit2 = hundreds.

Behaviour:
- Single clock domain; reset is asynchronous, active-high.
- Reset values:
  - prescaler = 0, index = 0, display_reg = 0, pending_reg = 0, pending_flag = 0.
  - update_ack = 0, seg = 7'h7F, digit_en = 3'b111.
  - Reset asserted mid-frame forces all of the above immediately and drops any pending value.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 in the cycle where the count equals TICK_DIV-1.
- Digit index:
  - On tick, advances 0→1→2→0.
  - A frame boundary is a tick while index = 2.
- Capture:
  - bcd_valid = 1 loads pending_reg ← bcd_in and sets pending_flag.
  - A later bcd_valid before the commit overwrites pending_reg; newest value wins, and no ack is issued for overwritten values.
- Commit, at a frame boundary with pending_flag = 1:
  - display_reg ← pending_reg, pending_flag cleared, update_ack = 1 for exactly the next cycle (registered).
  - No pending value at the boundary: display_reg is held and there is no ack.
- Simultaneous bcd_valid and frame boundary:
  - bcd_in bypasses pending_reg straight to display_reg.
  - pending_flag ends 0 and update_ack pulses.
- Digit decode:
  - Nibble = display_reg slice selected by the registered index.
  - Codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble > 9 shows a dash (7'h3F).
- Blanking, when blank_en = 1:
  - Hundreds is blank (7'h7F) if its nibble = 0.
  - Tens is blank if hundreds = 0 and tens = 0.
  - Units is never blanked.
  - A dash nibble counts as non-zero for blanking.
- Output registration:
  - seg and digit_en are registered and reflect the index and display_reg from the previous cycle (1-cycle latency).
  - digit_en is 3'b110, 3'b101 or 3'b011 for index 0, 1, 2. Exactly one bit is low outside reset.
  - The seg value changes in the same cycle as digit_en, so there is no cross-digit ghosting cycle.
- Changes to blank_en take effect at the next output register update; no frame alignment is required.

Test Plan (CLOCK_FREQ=8, SCAN_RATE=2, TICK_DIV=4):
- Reset release:
  - Stimulus: release reset, no stimulus.
  - Response: one cycle later digit_en = 110, seg = 7'h40 (display_reg = 0, units shows "0"); update_ack stays 0.
  - digit_en cycles 110→101→011 every 4 clocks.
- Load 12'h125 mid-frame:
  - Stimulus: bcd_valid pulse with bcd_in = 12'h125 while index = 0.
  - Response: display is unchanged until the index-2 tick. update_ack pulses once, one cycle after that tick.
  - Next frame: units seg = 7'h12, tens = 7'h24, hundreds = 7'h79.
- Blanking:
  - Stimulus: load 12'h007 with blank_en = 1.
  - Response: hundreds and tens show 7'h7F, units shows 7'h78.
  - Stimulus: then load 12'h000.
  - Response: units shows 7'h40, other digits blank. With blank_en = 0, 12'h007 shows 40/40/78.
- Dash and blanking interaction:
  - Stimulus: load 12'h0A3 with blank_en = 1.
  - Response: hundreds blank, tens = 7'h3F, units = 7'h30.
- Overwrite and simultaneous events:
  - Stimulus: bcd_valid with 12'h111, then 12'h222 before the boundary.
  - Response: display shows 222 and a single ack.
  - Stimulus: separately, bcd_valid coincident with the index-2 tick.
  - Response: that value is shown in the next frame and pending_flag = 0.
- Reset mid-operation:
  - Stimulus: load 12'h999 (pending), then assert reset asynchronously mid-cycle before the boundary.
  - Response: outputs go to 7'h7F / 3'b111 immediately.
  - After release: the display shows 0 and no ack occurs for 999.
